// File: rtl/gf2m_digit_mul.sv
// Digit-serial GF(2^M) multiplier, polynomial basis, MSB-first.
// Computes z = a*b mod f(x), f(x) = x^M + P(x), processing D bits of b per
// clock over N = ceil(M/D) iterations. done pulses one cycle when z is valid.
module gf2m_digit_mul #(
  parameter int unsigned M = 571,
  parameter int unsigned D = 32,
  parameter logic [M-1:0] P = 571'h425
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] z
);

  localparam int unsigned N  = (D == 0) ? 1 : (M + D - 1) / D;
  localparam int unsigned NB = N * D;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (M < 2 || D < 1 || D > M || P[0] == 1'b0) begin : g_bad_params
    $error("gf2m_digit_mul: illegal parameters (need M>=2, 1<=D<=M, P[0]=1)");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [M-1:0]    a_r;
  logic [NB-1:0]   b_r;
  logic [NB-1:0]   b_pad;
  logic [M-1:0]    acc;
  logic [M-1:0]    acc_next;
  logic [D-1:0]    digit;
  logic [CW-1:0]   cnt;

  // Zero-extend b at the MSB end to a whole number of digits.
  always_comb begin
    b_pad        = '0;
    b_pad[M-1:0] = b;
  end

  // One iteration: Horner over the current digit, folding the x^D shift of
  // acc and the a*digit partial product into a single reduce-as-you-go loop.
  always_comb begin
    digit    = b_r[NB-1 -: D];
    acc_next = acc;
    for (int unsigned i = 0; i < D; i++) begin
      acc_next = {acc_next[M-2:0], 1'b0} ^ ({M{acc_next[M-1]}} & P);
      if (digit[D-1-i]) begin
        acc_next = acc_next ^ a_r;
      end
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      acc   <= '0;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
    end else if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b_pad;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          b_r <= b_r << D;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            z     <= acc_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_mul.sv
// Scoreboard bench for gf2m_digit_mul: drivers push expected z values into
// per-instance queues, monitors pop and compare whenever done is seen.
module tb_gf2m_digit_mul;

  localparam logic [570:0] P571 = 571'h425;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic g_rst_n;

  task automatic check(input string nm, input logic [570:0] act, input logic [570:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s", nm);
  endtask

  // Reference: full carry-less product, then reduce from the top bit down.
  function automatic logic [570:0] gf_mul(input logic [570:0] x, input logic [570:0] y);
    logic [1141:0] p;
    p = '0;
    for (int i = 0; i < 571; i++)
      if (y[i]) p = p ^ ({571'b0, x} << i);
    for (int k = 1140; k >= 571; k--)
      if (p[k]) begin
        p[k] = 1'b0;
        p = p ^ ({571'b0, P571} << (k - 571));
      end
    return p[570:0];
  endfunction

  function automatic logic [570:0] rnd();
    logic [575:0] t;
    for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
    return t[570:0];
  endfunction

  // ---------------- main instance: M=571, D=32 ----------------
  logic         m_rst_n, m_clr, m_start, m_busy, m_done;
  logic [570:0] m_a, m_b, m_z;
  logic [570:0] mq[$];
  int unsigned  m_pushes = 0;
  int unsigned  m_dcnt   = 0;

  gf2m_digit_mul #(.M(571), .D(32), .P(P571)) u_main (
    .clk(clk), .rst_n(m_rst_n), .clr(m_clr), .start(m_start),
    .a(m_a), .b(m_b), .busy(m_busy), .done(m_done), .z(m_z)
  );

  always @(negedge clk) begin
    if (m_done) begin
      m_dcnt++;
      if (mq.size() == 0) flag("main_unexpected_done");
      else check("main_z", m_z, mq.pop_front());
    end
  end

  task automatic m_issue(input logic [570:0] ai, input logic [570:0] bi,
                         input logic [570:0] ex, input bit push);
    m_a = ai;
    m_b = bi;
    m_start = 1'b1;
    if (push) begin
      mq.push_back(ex);
      m_pushes++;
    end
    @(negedge clk);
    m_start = 1'b0;
  endtask

  task automatic m_wait_idle(input string nm);
    int c;
    c = 0;
    while (m_busy && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (m_busy) flag({nm, "_timeout busy stuck at 1"});
  endtask

  // ---------------- random instances: M=571, D in {1,17,571} ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int unsigned DD  = (gi == 0) ? 1 : (gi == 1) ? 17 : 571;
    localparam int unsigned OPS = (gi == 0) ? 3 : 10;
    logic         start, busy, done, fin;
    logic [570:0] a, b, z, ra, rb;
    logic [570:0] q[$];
    int unsigned  acc_cnt = 0;
    int unsigned  done_cnt = 0;
    int unsigned  cyc;

    gf2m_digit_mul #(.M(571), .D(DD), .P(P571)) u_dut (
      .clk(clk), .rst_n(g_rst_n), .clr(1'b0), .start(start),
      .a(a), .b(b), .busy(busy), .done(done), .z(z)
    );

    always @(negedge clk) begin
      if (done) begin
        done_cnt++;
        if (q.size() == 0) flag("rnd_unexpected_done");
        else check("rnd_z", z, q.pop_front());
      end
    end

    initial begin
      start = 1'b0; a = '0; b = '0; fin = 1'b0; cyc = 0;
      wait (g_rst_n === 1'b1);
      @(negedge clk);
      while (acc_cnt < OPS && cyc < 5000) begin
        if (!busy) begin
          ra = rnd(); rb = rnd();
          a = ra; b = rb; start = 1'b1;
          q.push_back(gf_mul(ra, rb));
          acc_cnt++;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      cyc = 0;
      while (done_cnt < acc_cnt && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      check("rnd_done_count", 571'(done_cnt), 571'(acc_cnt));
      fin = 1'b1;
    end
  end

  // ---------------- small field: M=7, P=x+1, D in {1,3,7} ----------------
  for (genvar gj = 0; gj < 3; gj++) begin : g_m7
    localparam int unsigned DD = (gj == 0) ? 1 : (gj == 1) ? 3 : 7;
    localparam int unsigned NN = (7 + DD - 1) / DD;
    logic        start, busy, done, fin;
    logic [6:0]  a, b, z;
    logic [6:0]  q[$];
    int unsigned dcnt = 0;
    int unsigned k;

    gf2m_digit_mul #(.M(7), .D(DD), .P(7'h03)) u_dut (
      .clk(clk), .rst_n(g_rst_n), .clr(1'b0), .start(start),
      .a(a), .b(b), .busy(busy), .done(done), .z(z)
    );

    always @(negedge clk) begin
      if (done) begin
        dcnt++;
        if (q.size() == 0) flag("m7_unexpected_done");
        else check("m7_z", 571'(z), 571'(q.pop_front()));
      end
    end

    initial begin
      start = 1'b0; a = '0; b = '0; fin = 1'b0;
      wait (g_rst_n === 1'b1);
      @(negedge clk);
      // x^6 * x^6 = x^12 = x^6 + x^5 mod x^7+x+1
      a = 7'h40; b = 7'h40; start = 1'b1; q.push_back(7'h60);
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (!done && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("m7_done_latency", 571'(k), 571'(NN + 1));
      @(negedge clk);
      // (x+1)(x^2+1) = x^3+x^2+x+1
      a = 7'h03; b = 7'h05; start = 1'b1; q.push_back(7'h0F);
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 50 && dcnt < 2; c++) @(negedge clk);
      check("m7_done_count", 571'(dcnt), 571'(2));
      fin = 1'b1;
    end
  end

  // Watchdog against a hung run.
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence on the main instance ----------------
  initial begin
    logic [570:0] ra, rb, top;
    int unsigned  k, bcnt, dc, n, cyc;

    m_rst_n = 1'b0; g_rst_n = 1'b0; m_clr = 1'b0; m_start = 1'b0;
    m_a = '0; m_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 571'(m_busy), 571'(0));
    check("reset_done", 571'(m_done), 571'(0));
    check("reset_z", m_z, '0);
    m_rst_n = 1'b1;
    g_rst_n = 1'b1;
    @(negedge clk);

    // 1*1: latency N=18, busy for 18 cycles, done a single cycle
    m_issue(571'd1, 571'd1, 571'd1, 1'b1);
    k = 1;
    bcnt = m_busy ? 1 : 0;
    while (!m_done && k < 100) begin
      @(negedge clk);
      k++;
      if (m_busy) bcnt++;
    end
    check("done_latency", 571'(k), 571'(19));
    check("busy_cycles", 571'(bcnt), 571'(18));
    @(negedge clk);
    check("done_one_cycle", 571'(m_done), 571'(0));

    // x^570 * x = x^571 = P(x)
    top = '0;
    top[570] = 1'b1;
    m_issue(top, 571'd2, 571'h425, 1'b1);
    m_wait_idle("wrap");
    repeat (5) @(negedge clk);
    check("z_hold", m_z, 571'h425);

    // restart and operand changes during RUN are ignored
    ra = rnd(); rb = rnd();
    m_issue(ra, rb, gf_mul(ra, rb), 1'b1);
    repeat (4) @(negedge clk);
    m_a = rnd(); m_b = rnd(); m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    m_a = rnd(); m_b = rnd();
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_done) dc++;
    end
    check("restart_done_pulses", 571'(dc), 571'(1));

    // clr mid-run (with simultaneous start) aborts
    m_issue(rnd(), rnd(), '0, 1'b0);
    repeat (4) @(negedge clk);
    m_clr = 1'b1; m_start = 1'b1;
    @(negedge clk);
    m_clr = 1'b0; m_start = 1'b0;
    check("clr_busy", 571'(m_busy), 571'(0));
    check("clr_done", 571'(m_done), 571'(0));
    check("clr_z", m_z, '0);

    // reset mid-run aborts
    m_issue(rnd(), rnd(), '0, 1'b0);
    repeat (4) @(negedge clk);
    m_rst_n = 1'b0; m_start = 1'b1;
    @(negedge clk);
    m_rst_n = 1'b1; m_start = 1'b0;
    check("rst_busy", 571'(m_busy), 571'(0));
    check("rst_z", m_z, '0);
    dc = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_done) dc++;
    end
    check("abort_no_done", 571'(dc), 571'(0));

    // normal operation after abort
    ra = rnd(); rb = rnd();
    m_issue(ra, rb, gf_mul(ra, rb), 1'b1);
    m_wait_idle("post_abort");
    @(negedge clk);

    // back-to-back random, start re-asserted in the DONE cycle
    n = 0;
    cyc = 0;
    while (n < 30 && cyc < 5000) begin
      if (!m_busy) begin
        ra = rnd(); rb = rnd();
        m_a = ra; m_b = rb; m_start = 1'b1;
        mq.push_back(gf_mul(ra, rb));
        m_pushes++;
        n++;
      end else begin
        m_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    m_start = 1'b0;
    m_wait_idle("b2b");
    repeat (2) @(negedge clk);
    check("main_done_count", 571'(m_dcnt), 571'(m_pushes));
    check("main_queue_empty", 571'(mq.size()), 571'(0));

    cyc = 0;
    while (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin &&
             g_m7[0].fin && g_m7[1].fin && g_m7[2].fin) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (!(g_rnd[0].fin && g_rnd[1].fin && g_rnd[2].fin &&
          g_m7[0].fin && g_m7[1].fin && g_m7[2].fin))
      flag("streams_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
